// File: rtl/lb_arb_pkg.sv
// Shared state encoding and sizing helper for the local-bus arbiter slice.
package lb_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed to hold the values 0..value-1, never fewer than one.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int v = value - 1; v > 0; v = v >> 1) bits++;
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/lb_rr_pick.sv
// Combinational round-robin picker: first requester above ptr, wrapping.
module lb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // Scan ptr+1 .. ptr+N modulo N and keep the first hit.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] ci;
        logic             found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        ci    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            ci = IDX_W'(cand);
            if (!found && req[ci]) begin
                found     = 1'b1;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end

endmodule

// File: rtl/lb_arb.sv
// Round-robin arbiter sharing one LB slave between several LB masters,
// one transaction outstanding, with a timeout for a silent slave.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; arbitrate among requesting masters
// WAIT    | slave strobed (first cycle); waiting for matching valid
// DONE    | one cycle: completion pulse routed to the granted master
module lb_arb
    import lb_arb_pkg::*;
#(
    parameter int                NUM_MASTERS    = 2,
    parameter int                LB_DATA_W      = 32,
    parameter int                LB_ADDR_W      = 12,
    parameter int                TIMEOUT_CYCLES = 16,
    parameter logic [LB_DATA_W-1:0] TIMEOUT_RD_VAL = 'hdeadbabe
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_MASTERS-1:0]           m_wr_en,
    input  logic [NUM_MASTERS-1:0]           m_rd_en,
    input  logic [NUM_MASTERS*LB_ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*LB_DATA_W-1:0] m_wr_data,
    output logic [NUM_MASTERS-1:0]           m_wr_valid,
    output logic [NUM_MASTERS-1:0]           m_rd_valid,
    output logic [LB_DATA_W-1:0]             m_rd_data,
    output logic                             s_wr_en,
    output logic                             s_rd_en,
    output logic [LB_ADDR_W-1:0]             s_addr,
    output logic [LB_DATA_W-1:0]             s_wr_data,
    input  logic                             s_wr_valid,
    input  logic                             s_rd_valid,
    input  logic [LB_DATA_W-1:0]             s_rd_data,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int IDX_W = clog2(NUM_MASTERS);
    localparam int TMR_W = clog2(TIMEOUT_CYCLES);

    state_t                 state;
    logic [IDX_W-1:0]       ptr;
    logic [NUM_MASTERS-1:0] gnt_oh;
    logic                   is_wr;
    logic [TMR_W-1:0]       timer;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_wr;
    logic [LB_ADDR_W-1:0]   pick_addr;
    logic [LB_DATA_W-1:0]   pick_data;
    logic                   tmo_hit;

    assign req     = m_wr_en | m_rd_en;
    // A master holding both enables gets its write served first.
    assign pick_wr = |(pick_grant & m_wr_en);
    assign tmo_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    lb_rr_pick #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Select the winning master's address and write data.
    always_comb begin
        pick_addr = '0;
        pick_data = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick_grant[i]) begin
                pick_addr = m_addr[i*LB_ADDR_W +: LB_ADDR_W];
                pick_data = m_wr_data[i*LB_DATA_W +: LB_DATA_W];
            end
        end
    end

    // Transaction FSM with registered slave strobes and master completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= IDX_W'(NUM_MASTERS - 1);
            gnt_oh      <= '0;
            is_wr       <= 1'b0;
            timer       <= '0;
            s_wr_en     <= 1'b0;
            s_rd_en     <= 1'b0;
            s_addr      <= '0;
            s_wr_data   <= '0;
            m_wr_valid  <= '0;
            m_rd_valid  <= '0;
            m_rd_data   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            s_wr_en     <= 1'b0;
            s_rd_en     <= 1'b0;
            m_wr_valid  <= '0;
            m_rd_valid  <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        ptr       <= pick_idx;
                        gnt_oh    <= pick_grant;
                        is_wr     <= pick_wr;
                        s_addr    <= pick_addr;
                        s_wr_data <= pick_data;
                        s_wr_en   <= pick_wr;
                        s_rd_en   <= ~pick_wr;
                        timer     <= '0;
                        busy      <= 1'b1;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    if (is_wr && s_wr_valid) begin
                        m_wr_valid <= gnt_oh;
                        state      <= ST_DONE;
                    end else if (!is_wr && s_rd_valid) begin
                        m_rd_valid <= gnt_oh;
                        m_rd_data  <= s_rd_data;
                        state      <= ST_DONE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        if (is_wr) begin
                            m_wr_valid <= gnt_oh;
                        end else begin
                            m_rd_valid <= gnt_oh;
                            m_rd_data  <= TIMEOUT_RD_VAL;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lb_arb.sv
// Bench for lb_arb: table of single transactions plus hand-written
// sequences (arbitration order, write+read, timeout, reset abort).
module tb_lb_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_wr_en, m_rd_en;
    logic [23:0] m_addr;
    logic [63:0] m_wr_data;
    logic [1:0]  m_wr_valid, m_rd_valid;
    logic [31:0] m_rd_data;
    logic        s_wr_en, s_rd_en;
    logic [11:0] s_addr;
    logic [31:0] s_wr_data;
    logic        s_wr_valid, s_rd_valid;
    logic [31:0] s_rd_data;
    logic        busy, timeout_err;

    lb_arb #(
        .NUM_MASTERS    (2),
        .LB_DATA_W      (32),
        .LB_ADDR_W      (12),
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RD_VAL (32'hdeadbabe)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_wr_en     (m_wr_en),
        .m_rd_en     (m_rd_en),
        .m_addr      (m_addr),
        .m_wr_data   (m_wr_data),
        .m_wr_valid  (m_wr_valid),
        .m_rd_valid  (m_rd_valid),
        .m_rd_data   (m_rd_data),
        .s_wr_en     (s_wr_en),
        .s_rd_en     (s_rd_en),
        .s_addr      (s_addr),
        .s_wr_data   (s_wr_data),
        .s_wr_valid  (s_wr_valid),
        .s_rd_valid  (s_rd_valid),
        .s_rd_data   (s_rd_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          m;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          m;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          tmo;
        int          t0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        vec[7];
    int          checks = 0;
    int          failures = 0;
    int          n_swr, n_srd, n_valid, n_tmo, nv0, t0;
    int          wr_rep[2];
    logic [31:0] last_rd;

    // slave model state
    logic [31:0] mem[16];
    bit          slave_on, pend_wr, pend_rd, inj_rd;
    logic [31:0] rd_buf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_en"},      {s_wr_en, s_rd_en}, 0);
        chk({tag, "_s_addr"},    s_addr, 0);
        chk({tag, "_s_wr_data"}, s_wr_data, 0);
        chk({tag, "_m_valid"},   {m_wr_valid, m_rd_valid}, 0);
        chk({tag, "_m_rd_data"}, m_rd_data, 0);
        chk({tag, "_busy_tmo"},  {busy, timeout_err}, 0);
    endtask

    task automatic drive(input int m, input bit wr, input logic [11:0] addr, input logic [31:0] data);
        m_addr[m*12 +: 12]    = addr;
        m_wr_data[m*32 +: 32] = data;
        m_wr_en[m]            = wr;
        m_rd_en[m]            = !wr;
    endtask

    task automatic push(input int m, input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input bit tmo, input int ts, input int lat);
        exp_t e;
        e.m = m; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        e.tmo = tmo; e.t0 = ts; e.lat = lat;
        sb.push_back(e);
    endtask

    // One-cycle-latency slave with a small memory; can be silenced or made
    // to emit a stray read valid.
    task automatic slave_step();
        s_wr_valid = 1'b0;
        s_rd_valid = 1'b0;
        if (!rst_n) begin
            pend_wr = 0;
            pend_rd = 0;
        end
        if (inj_rd) begin
            s_rd_valid = 1'b1;
            s_rd_data  = 32'h1234_5678;
            inj_rd     = 0;
        end
        if (pend_wr) begin
            s_wr_valid = 1'b1;
            pend_wr    = 0;
        end
        if (pend_rd) begin
            s_rd_valid = 1'b1;
            s_rd_data  = rd_buf;
            pend_rd    = 0;
        end
        if (rst_n && slave_on && s_wr_en) begin
            mem[s_addr[3:0]] = s_wr_data;
            pend_wr = 1;
        end
        if (rst_n && slave_on && s_rd_en) begin
            rd_buf  = mem[s_addr[3:0]];
            pend_rd = 1;
        end
    endtask

    // Scoreboard: check slave strobes against the in-flight entry, pop on
    // completion, and model masters dropping served requests.
    task automatic mon_step();
        exp_t       e;
        logic [1:0] oh;
        if (!rst_n) return;
        if (timeout_err) n_tmo++;
        if (s_wr_en || s_rd_en) begin
            n_swr += int'(s_wr_en);
            n_srd += int'(s_rd_en);
            if (sb.size() == 0) begin
                chk("unexpected_s_en", {s_wr_en, s_rd_en}, 0);
            end else begin
                e = sb[0];
                chk("s_en_type", {s_wr_en, s_rd_en}, e.wr ? 2'b10 : 2'b01);
                chk("s_addr", s_addr, e.addr);
                if (e.wr) chk("s_wr_data", s_wr_data, e.wdata);
                chk("s_en_cycle", cyc, e.t0 + 1);
                chk("busy_in_wait", busy, 1);
            end
        end
        if (m_wr_valid != 0 || m_rd_valid != 0) begin
            n_valid++;
            if (sb.size() == 0) begin
                chk("unexpected_valid", {m_wr_valid, m_rd_valid}, 0);
            end else begin
                e  = sb.pop_front();
                oh = 2'b01 << e.m;
                chk("valid_vec", {m_wr_valid, m_rd_valid}, e.wr ? {oh, 2'b00} : {2'b00, oh});
                if (!e.wr) chk("rd_data", m_rd_data, e.rdata);
                chk("timeout_err", timeout_err, e.tmo);
                chk("valid_cycle", cyc, e.t0 + e.lat);
            end
            for (int i = 0; i < 2; i++) begin
                if (m_wr_valid[i]) begin
                    if (wr_rep[i] > 0) wr_rep[i]--;
                    else m_wr_en[i] = 1'b0;
                end
                if (m_rd_valid[i]) m_rd_en[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
        mon_step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{0, 1'b1, 12'h000, 32'h0000_0003, 32'h0};
        vec[1] = '{1, 1'b0, 12'h000, 32'h0,         32'h0000_0003};
        vec[2] = '{1, 1'b1, 12'h00a, 32'ha5a5_0001, 32'h0};
        vec[3] = '{0, 1'b0, 12'h00a, 32'h0,         32'ha5a5_0001};
        vec[4] = '{0, 1'b0, 12'h00f, 32'h0,         32'h0};
        vec[5] = '{1, 1'b1, 12'h000, 32'hffff_ffff, 32'h0};
        vec[6] = '{0, 1'b0, 12'h000, 32'h0,         32'hffff_ffff};

        rst_n = 1'b0;
        m_wr_en = '0; m_rd_en = '0; m_addr = '0; m_wr_data = '0;
        s_wr_valid = 1'b0; s_rd_valid = 1'b0; s_rd_data = '0;
        slave_on = 1; pend_wr = 0; pend_rd = 0; inj_rd = 0; rd_buf = '0;
        n_swr = 0; n_srd = 0; n_valid = 0; n_tmo = 0; last_rd = '0;
        wr_rep[0] = 0; wr_rep[1] = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // single transactions, 1-cycle slave: valid at T+3, idle at T+4
        for (int v = 0; v < 7; v++) begin
            t0 = cyc;
            drive(vec[v].m, vec[v].wr, vec[v].addr, vec[v].wdata);
            push(vec[v].m, vec[v].wr, vec[v].addr, vec[v].wdata, vec[v].rdata, 0, t0, 3);
            repeat (4) tick();
            chk("vec_complete", sb.size(), 0);
            chk("vec_busy_low", busy, 0);
            if (!vec[v].wr) last_rd = vec[v].rdata;
            chk("rd_data_hold", m_rd_data, last_rd);
        end

        // write and read held together: write first, then the read
        n_swr = 0; n_srd = 0;
        t0 = cyc;
        m_addr[11:0] = 12'h005; m_wr_data[31:0] = 32'h0000_0055;
        m_wr_en[0] = 1'b1; m_rd_en[0] = 1'b1;
        push(0, 1, 12'h005, 32'h55, 32'h0, 0, t0, 3);
        push(0, 0, 12'h005, 32'h0, 32'h55, 0, t0 + 4, 3);
        repeat (9) tick();
        chk("wr_rd_complete", sb.size(), 0);
        chk("wr_rd_s_wr_en_pulses", n_swr, 1);
        chk("wr_rd_s_rd_en_pulses", n_srd, 1);

        // silent slave on a read: timeout at T+9, stray valid later ignored
        slave_on = 0; n_tmo = 0;
        t0 = cyc;
        drive(1, 0, 12'h007, 32'h0);
        push(1, 0, 12'h007, 32'h0, 32'hdeadbabe, 1, t0, 9);
        repeat (10) tick();
        chk("tmo_complete", sb.size(), 0);
        chk("tmo_pulses", n_tmo, 1);
        nv0 = n_valid;
        inj_rd = 1;
        repeat (4) tick();
        chk("late_valid_dropped", n_valid - nv0, 0);
        chk("late_valid_rd_data", m_rd_data, 32'hdeadbabe);
        chk("late_valid_busy", busy, 0);
        chk("tmo_pulses_after", n_tmo, 1);

        // reset in the second WAIT cycle aborts the transaction
        t0 = cyc;
        drive(0, 1, 12'h00c, 32'h00c0_ffee);
        push(0, 1, 12'h00c, 32'h00c0_ffee, 32'h0, 0, t0, 3);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        sb.delete();
        m_wr_en = '0; m_rd_en = '0;
        tick();
        rst_n = 1'b1; slave_on = 1;
        tick();

        // master 1 alone after reset is served
        t0 = cyc;
        drive(1, 0, 12'h00a, 32'h0);
        push(1, 0, 12'h00a, 32'h0, 32'ha5a5_0001, 0, t0, 3);
        repeat (4) tick();
        chk("m1_alone_complete", sb.size(), 0);

        // both masters continuously after reset: order 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr_rep[0] = 1; wr_rep[1] = 1;
        t0 = cyc;
        drive(0, 1, 12'h001, 32'h0000_0a00);
        drive(1, 1, 12'h002, 32'h0000_0b00);
        push(0, 1, 12'h001, 32'h0a00, 32'h0, 0, t0, 3);
        push(1, 1, 12'h002, 32'h0b00, 32'h0, 0, t0 + 4, 3);
        push(0, 1, 12'h001, 32'h0a00, 32'h0, 0, t0 + 8, 3);
        push(1, 1, 12'h002, 32'h0b00, 32'h0, 0, t0 + 12, 3);
        repeat (16) tick();
        chk("rr_complete", sb.size(), 0);
        chk("rr_requests_dropped", {m_wr_en, m_rd_en}, 0);
        chk("rr_busy_low", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
